// File: rtl/ext_int_pkg.sv
// ext_int_pkg: shared types for the external interrupt controller
package ext_int_pkg;
    typedef enum logic [1:0] {SENSE_RISE, SENSE_FALL, SENSE_CHANGE, SENSE_LEVEL_LOW} sense_e;
    typedef enum logic {DET_DETECT, DET_DEBOUNCE} det_state_e;
endpackage

// File: rtl/ext_int_channel.sv
// ext_int_channel: one interrupt pin with optional sync, edge/level detect, debounce and sticky pending
// Ports: clk, rst (async, active-high), pin (raw pin), enable, sense (mode),
//        debounce (blanking enable), clear (pending clear), pending (sticky flag).
// Macro EXT_INT_SYNC_EN adds a 2-flop synchronizer ahead of the detector.
module ext_int_channel
    import ext_int_pkg::*;
#(
    parameter logic PIN_IDLE         = 1'b1,
    parameter int   DEBOUNCE_TIMEOUT = 20,
    parameter int   CNT_W            = $clog2(DEBOUNCE_TIMEOUT + 1)
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pin,
    input  logic   enable,
    input  sense_e sense,
    input  logic   debounce,
    input  logic   clear,
    output logic   pending
);
    logic s, p, evt, set;
    det_state_e state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
`ifdef EXT_INT_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= {2{PIN_IDLE}};
        else     sync <= {sync[0], pin};
    assign s = sync[1];
`else
    assign s = pin;
`endif
    assign evt = (sense == SENSE_RISE)   ? ~p & s :
                 (sense == SENSE_FALL)   ? p & ~s :
                 (sense == SENSE_CHANGE) ? p ^ s  : ~s;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        set     = 1'b0;
        if (!enable) begin
            state_n = DET_DETECT;
            cnt_n   = '0;
        end else if (state == DET_DETECT) begin
            set = evt;
            if (evt && debounce && sense != SENSE_LEVEL_LOW) state_n = DET_DEBOUNCE;
        end else if (cnt == CNT_W'(DEBOUNCE_TIMEOUT - 1)) begin
            state_n = DET_DETECT;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    // History tracks the pin every cycle, so enabling never fires on a stale level.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            p       <= PIN_IDLE;
            state   <= DET_DETECT;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            p       <= s;
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= set ? 1'b1 : clear ? 1'b0 : pending;
        end
endmodule

// File: rtl/ext_int_controller.sv
// ext_int_controller: NUM_CH external interrupt channels with fixed-priority valid/ack arbiter
// Ports: clk, rst (async, active-high), int_pin, enable_interrupt, sense_control (2 bits/ch),
//        debounce_option, pending_clear (W1C), pending, irq_valid, irq_id, irq_ack.
// Macro EXT_INT_SYNC_EN adds per-pin 2-flop synchronizers (+2 cycles latency).
module ext_int_controller
    import ext_int_pkg::*;
#(
    parameter int                NUM_CH           = 8,
    parameter logic [NUM_CH-1:0] PIN_IDLE_STATE   = {NUM_CH{1'b1}},
    parameter int                DEBOUNCE_TIMEOUT = 20,
    parameter int                CNT_W            = $clog2(DEBOUNCE_TIMEOUT + 1),
    parameter int                ID_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   int_pin,
    input  logic [NUM_CH-1:0]   enable_interrupt,
    input  logic [2*NUM_CH-1:0] sense_control,
    input  logic [NUM_CH-1:0]   debounce_option,
    input  logic [NUM_CH-1:0]   pending_clear,
    output logic [NUM_CH-1:0]   pending,
    output logic                irq_valid,
    output logic [ID_W-1:0]     irq_id,
    input  logic                irq_ack
);
    logic [NUM_CH-1:0] req;
    logic [ID_W-1:0]   low_id;
    assign req = pending & enable_interrupt;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ext_int_channel #(
            .PIN_IDLE        (PIN_IDLE_STATE[i]),
            .DEBOUNCE_TIMEOUT(DEBOUNCE_TIMEOUT),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .pin     (int_pin[i]),
            .enable  (enable_interrupt[i]),
            .sense   (sense_e'(sense_control[2*i +: 2])),
            .debounce(debounce_option[i]),
            .clear   (pending_clear[i] | (irq_ack & irq_valid & (irq_id == ID_W'(i)))),
            .pending (pending[i])
        );
    end
    // Descending scan leaves the lowest requesting index.
    always_comb begin
        low_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[i]) low_id = ID_W'(i);
    end
    // A grant holds until acked or withdrawn; either way one idle cycle precedes re-arbitration.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else if (!irq_valid) begin
            irq_valid <= |req;
            irq_id    <= low_id;
        end else if (irq_ack || !pending[irq_id]) begin
            irq_valid <= 1'b0;
        end
endmodule

// File: tb/tb_ext_int_controller.sv
// tb_ext_int_controller: directed self-checking bench for ext_int_controller
module tb_ext_int_controller;
    import ext_int_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_pin;
    logic [7:0]  enable_interrupt;
    logic [15:0] sense_control;
    logic [7:0]  debounce_option;
    logic [7:0]  pending_clear;
    logic [7:0]  pending;
    logic        irq_valid;
    logic [2:0]  irq_id;
    logic        irq_ack;
    int          n_chk = 0;
    int          n_pass = 0;

    ext_int_controller #(.NUM_CH(8), .DEBOUNCE_TIMEOUT(20)) dut (
        .clk             (clk),
        .rst             (rst),
        .int_pin         (int_pin),
        .enable_interrupt(enable_interrupt),
        .sense_control   (sense_control),
        .debounce_option (debounce_option),
        .pending_clear   (pending_clear),
        .pending         (pending),
        .irq_valid       (irq_valid),
        .irq_id          (irq_id),
        .irq_ack         (irq_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_irq(input string tag, input logic v, input logic [2:0] id);
        check({tag, "_valid"}, 32'(irq_valid), 32'(v));
        if (v) check({tag, "_id"}, 32'(irq_id), 32'(id));
    endtask

    task automatic idle();
        enable_interrupt = 8'h00;
        int_pin          = 8'hFF;
        pending_clear    = 8'hFF;
        irq_ack          = 1'b0;
        step();
        pending_clear = 8'h00;
        step();
        step();
    endtask

    initial begin
        rst              = 1'b1;
        int_pin          = 8'hFF;
        enable_interrupt = 8'h00;
        sense_control    = 16'h0000;
        debounce_option  = 8'h00;
        pending_clear    = 8'h00;
        irq_ack          = 1'b0;
        #2;
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_valid", 32'(irq_valid), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);
        step();
        rst = 1'b0;
        step();

        // 1: ch3 rise
        enable_interrupt = 8'h08;
        int_pin[3] = 1'b0;
        step();
        check("t1_no_fall", 32'(pending), 32'h00);
        int_pin[3] = 1'b1;
        step();
        check("t1_pending", 32'(pending), 32'h08);
        check("t1_not_yet", 32'(irq_valid), 32'h0);
        step();
        check_irq("t1_grant", 1'b1, 3'd3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t1_ack_pending", 32'(pending), 32'h00);
        check("t1_ack_valid", 32'(irq_valid), 32'h0);
        step();
        check("t1_stay_idle", 32'(irq_valid), 32'h0);
        idle();

        // 2: ch1 and ch5 fall together
        sense_control    = 16'h0404;
        enable_interrupt = 8'h22;
        int_pin          = 8'hDD;
        step();
        check("t2_pending", 32'(pending), 32'h22);
        step();
        check_irq("t2_first", 1'b1, 3'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_after_ack", 32'(pending), 32'h20);
        check("t2_gap", 32'(irq_valid), 32'h0);
        step();
        check_irq("t2_second", 1'b1, 3'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_done", 32'(pending), 32'h00);
        idle();

        // 3: ch0 change with 20-cycle debounce
        sense_control    = 16'h0002;
        debounce_option  = 8'h01;
        enable_interrupt = 8'h01;
        step();
        int_pin[0] = 1'b0;
        step();
        check("t3_first", 32'(pending), 32'h01);
        int_pin[0]    = 1'b1;
        pending_clear = 8'h01;
        step();
        pending_clear = 8'h00;
        check("t3_bounce_ignored", 32'(pending), 32'h00);
        check_irq("t3_grant", 1'b1, 3'd0);
        for (int i = 0; i < 9; i++) begin
            if (i < 5) int_pin[0] = ~int_pin[0];
            step();
            if (i == 0) check("t3_withdrawn", 32'(irq_valid), 32'h0);
        end
        check("t3_blanked", 32'(pending), 32'h00);
        for (int i = 0; i < 9; i++) step();
        int_pin[0] = ~int_pin[0];
        step();
        check("t3_last_blank", 32'(pending), 32'h00);
        int_pin[0] = ~int_pin[0];
        step();
        check("t3_rearmed", 32'(pending), 32'h01);
        pending_clear    = 8'h01;
        enable_interrupt = 8'h00;
        step();
        pending_clear = 8'h00;
        check("t3_cleared", 32'(pending), 32'h00);
        check("t3_no_grant", 32'(irq_valid), 32'h0);
        debounce_option = 8'h00;
        idle();

        // 4: ch2 level-low, set beats clear
        sense_control    = 16'h0030;
        enable_interrupt = 8'h04;
        int_pin[2]       = 1'b0;
        step();
        check("t4_level", 32'(pending), 32'h04);
        pending_clear = 8'h04;
        step();
        pending_clear = 8'h00;
        check("t4_set_wins", 32'(pending), 32'h04);
        check_irq("t4_grant", 1'b1, 3'd2);
        int_pin[2] = 1'b1;
        step();
        check("t4_sticky", 32'(pending), 32'h04);
        pending_clear = 8'h04;
        step();
        pending_clear = 8'h00;
        check("t4_cleared", 32'(pending), 32'h00);
        step();
        check("t4_withdrawn", 32'(irq_valid), 32'h0);
        idle();

        // 5: ch4 disabled toggling, then enable on static pin; reset mid-debounce
        sense_control   = 16'h0000;
        debounce_option = 8'h10;
        for (int i = 0; i < 4; i++) begin
            int_pin[4] = ~int_pin[4];
            step();
        end
        check("t5_disabled", 32'(pending), 32'h00);
        enable_interrupt = 8'h10;
        step();
        check("t5_enable_static", 32'(pending), 32'h00);
        step();
        check("t5_no_grant", 32'(irq_valid), 32'h0);
        int_pin[4] = 1'b0;
        step();
        int_pin[4] = 1'b1;
        step();
        check("t5_rise", 32'(pending), 32'h10);
        step();
        check_irq("t5_grant", 1'b1, 3'd4);
        check("t5_in_debounce", 32'(dut.g_ch[4].u_ch.state), 32'(DET_DEBOUNCE));
        rst = 1'b1;
        #1;
        check("t5_rst_pending", 32'(pending), 32'h00);
        check("t5_rst_valid", 32'(irq_valid), 32'h0);
        check("t5_rst_id", 32'(irq_id), 32'h0);
        check("t5_rst_state", 32'(dut.g_ch[4].u_ch.state), 32'(DET_DETECT));
        #1;
        rst = 1'b0;
        int_pin[4] = 1'b0;
        step();
        int_pin[4] = 1'b1;
        step();
        check("t5_detect_after_rst", 32'(pending), 32'h10);
        debounce_option = 8'h00;
        idle();

        // 6: lower index arrives while id 6 is granted
        enable_interrupt = 8'h41;
        int_pin[6] = 1'b0;
        step();
        int_pin[6] = 1'b1;
        step();
        check("t6_pending6", 32'(pending), 32'h40);
        step();
        check_irq("t6_grant6", 1'b1, 3'd6);
        int_pin[0] = 1'b0;
        step();
        int_pin[0] = 1'b1;
        step();
        check("t6_both", 32'(pending), 32'h41);
        check_irq("t6_hold", 1'b1, 3'd6);
        step();
        check_irq("t6_hold2", 1'b1, 3'd6);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t6_ack6", 32'(pending), 32'h01);
        check("t6_gap", 32'(irq_valid), 32'h0);
        step();
        check_irq("t6_grant0", 1'b1, 3'd0);
        irq_ack = 1'b1;
        step();
        check("t6_ack0", 32'(pending), 32'h00);
        check("t6_idle", 32'(irq_valid), 32'h0);
        step();
        irq_ack = 1'b0;
        check("t6_ack_ignored", 32'(irq_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
